// File: rtl/lc3b_pkg.sv
// Shared encodings for the fetch stage: PC mux selects, queue FSM states,
// and the fixed instruction step.
package lc3b_pkg;

    typedef enum logic [1:0] {
        PCMUX_NONE   = 2'd0,
        PCMUX_TARGET = 2'd1,
        PCMUX_TRAP   = 2'd2,
        PCMUX_ZERO   = 2'd3
    } pcmux_e;

    typedef enum logic {
        FQ_RUN  = 1'b0,
        FQ_HOLD = 1'b1
    } fq_state_e;

    localparam int INSTR_STEP = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for queued fetches, DEPTH entries of W bits.
// A separate count distinguishes full from empty; flush beats push and pop.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign dout = mem[head];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && count == '0));
    a_count_range: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC register, prefetch queue toward DE, hold FSM for branch
// stalls and flush on MEM redirects.
import lc3b_pkg::*;

module fetch_queue_stage #(
    parameter int          AW       = 16,
    parameter int          IW       = 16,
    parameter int          DEPTH    = 4,
    parameter int          NBR      = 3,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int          CW       = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    output logic [AW-1:0]  imem_addr,
    output logic           imem_req,
    input  logic           imem_r,
    input  logic [IW-1:0]  instr,
    input  logic [1:0]     mem_pcmux,
    input  logic [AW-1:0]  target_pc,
    input  logic [AW-1:0]  trap_pc,
    input  logic [NBR-1:0] br_stall,
    input  logic           ld_de,
    output logic           de_v,
    output logic [IW-1:0]  de_ir,
    output logic [AW-1:0]  de_npc,
    output logic [AW-1:0]  pc,
    output logic [CW-1:0]  q_count
);

    fq_state_e        state;
    logic             redirect;
    logic             stall;
    logic             push;
    logic             pop;
    logic [AW-1:0]    pc_next;
    logic [AW+IW-1:0] head;

    assign stall     = |br_stall;
    assign redirect  = mem_pcmux != PCMUX_NONE;
    assign pc_next   = pc + AW'(INSTR_STEP);
    assign imem_addr = pc;

    assign de_v   = (q_count != '0) && !stall && !redirect;
    assign pop    = de_v && ld_de;
    assign de_ir  = de_v ? head[IW-1:0] : '0;
    assign de_npc = de_v ? head[AW+IW-1:IW] : '0;

    // A full queue may still fetch when the head leaves in the same cycle.
    assign imem_req = !reset && state == FQ_RUN && !stall && !redirect
                    && (q_count < CW'(DEPTH) || pop);
    assign push = imem_req && imem_r;

    fetch_fifo #(
        .W     (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({pc_next, instr}),
        .dout  (head),
        .count (q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= FQ_RUN;
        end else begin
            unique case (pcmux_e'(mem_pcmux))
                PCMUX_TARGET: pc <= target_pc;
                PCMUX_TRAP:   pc <= trap_pc;
                PCMUX_ZERO:   pc <= '0;
                PCMUX_NONE:   if (push) pc <= pc_next;
            endcase
            unique case (state)
                FQ_RUN:  if (stall && !redirect) state <= FQ_HOLD;
                FQ_HOLD: if (!stall || redirect) state <= FQ_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed plus randomized bench for fetch_queue_stage, checked against a
// queue-based reference model of the fetch/issue rules.
module tb_fetch_queue_stage;

    logic        clk;
    logic        reset;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_r;
    logic [15:0] instr;
    logic [1:0]  mem_pcmux;
    logic [15:0] target_pc;
    logic [15:0] trap_pc;
    logic [2:0]  br_stall;
    logic        ld_de;
    logic        de_v;
    logic [15:0] de_ir;
    logic [15:0] de_npc;
    logic [15:0] pc;
    logic [2:0]  q_count;

    int checks;
    int failures;

    fetch_queue_stage dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_r    (imem_r),
        .instr     (instr),
        .mem_pcmux (mem_pcmux),
        .target_pc (target_pc),
        .trap_pc   (trap_pc),
        .br_stall  (br_stall),
        .ld_de     (ld_de),
        .de_v      (de_v),
        .de_ir     (de_ir),
        .de_npc    (de_npc),
        .pc        (pc),
        .q_count   (q_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] npc;
        logic [15:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mpc;
    bit          mhold;
    bit          e_v, e_pop, e_req;
    logic [15:0] e_ir, e_npc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = 16'h0000;
        mhold = 0;
    endtask

    task automatic settle();
        bit stl, rd;
        #1;
        if (reset) model_reset();
        stl   = br_stall != 0;
        rd    = mem_pcmux != 0;
        e_v   = mq.size() != 0 && !stl && !rd;
        e_pop = e_v && ld_de;
        e_req = !reset && !mhold && !stl && !rd && (mq.size() < 4 || e_pop);
        e_ir  = e_v ? mq[0].ir : 16'h0;
        e_npc = e_v ? mq[0].npc : 16'h0;
        chk("imem_req", imem_req, e_req);
        chk("imem_addr", imem_addr, mpc);
        chk("pc", pc, mpc);
        chk("de_v", de_v, e_v);
        chk("de_ir", de_ir, e_ir);
        chk("de_npc", de_npc, e_npc);
        chk("q_count", q_count, mq.size());
    endtask

    task automatic tick();
        bit stl;
        ent_t e;
        @(posedge clk);
        stl = br_stall != 0;
        if (reset) begin
            model_reset();
        end else if (mem_pcmux != 0) begin
            mq.delete();
            mpc   = (mem_pcmux == 1) ? target_pc :
                    (mem_pcmux == 2) ? trap_pc : 16'h0000;
            mhold = 0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_req && imem_r) begin
                e.npc = mpc + 16'd2;
                e.ir  = instr;
                mq.push_back(e);
                mpc = mpc + 16'd2;
            end
            if (!mhold && stl) mhold = 1;
            else if (mhold && !stl) mhold = 0;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        logic [15:0] held_npc;
        checks    = 0;
        failures  = 0;
        reset     = 1;
        imem_r    = 0;
        instr     = 16'h0;
        mem_pcmux = 0;
        target_pc = 16'h0;
        trap_pc   = 16'h0;
        br_stall  = 0;
        ld_de     = 0;
        model_reset();
        @(negedge clk);
        cyc();

        // reset mid-run with three queued entries
        reset = 0;
        imem_r = 1;
        for (int i = 0; i < 3; i++) begin
            instr = 16'h1000 + 16'(i);
            cyc();
        end
        chk("t1_fill", q_count, 3);
        reset = 1;
        cyc();
        reset  = 0;
        imem_r = 0;
        settle();
        chk("t1_req", imem_req, 1);
        chk("t1_pc", pc, 16'h0000);
        chk("t1_cnt", q_count, 0);
        tick();

        // fill while DE stalls, then drain in order
        imem_r = 1;
        for (int i = 0; i < 6; i++) begin
            instr = 16'h2000 + 16'(i);
            cyc();
        end
        chk("t2_full", q_count, 4);
        chk("t2_noreq", imem_req, 0);
        imem_r = 0;
        ld_de  = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_npc", de_npc, 32'(2 * (i + 1)));
            tick();
        end

        // full queue with simultaneous push and pop
        ld_de  = 0;
        imem_r = 1;
        for (int i = 0; i < 4; i++) begin
            instr = 16'h3000 + 16'(i);
            cyc();
        end
        ld_de = 1;
        for (int i = 0; i < 5; i++) begin
            instr = 16'h3100 + 16'(i);
            settle();
            chk("t3_req", imem_req, 1);
            tick();
            chk("t3_cnt", q_count, 4);
            chk("t3_pc", pc, 32'(16'h0010 + 16'(2 * (i + 1))));
        end

        // branch stall holds the queue
        imem_r = 0;
        cyc();
        cyc();
        chk("t4_cnt", q_count, 2);
        held_npc = mq[0].npc;
        br_stall = 3'b010;
        imem_r   = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_dev", de_v, 0);
            chk("t4_req", imem_req, 0);
            tick();
        end
        br_stall = 0;
        imem_r   = 0;
        ld_de    = 0;
        settle();
        chk("t4_head", de_npc, held_npc);
        chk("t4_cnt2", q_count, 2);
        tick();

        // redirect drops the concurrent fetch
        imem_r = 1;
        instr  = 16'h4444;
        cyc();
        chk("t5_cnt", q_count, 3);
        mem_pcmux = 1;
        target_pc = 16'h3000;
        instr     = 16'hDEAD;
        cyc();
        mem_pcmux = 0;
        imem_r    = 0;
        settle();
        chk("t5_pc", pc, 16'h3000);
        chk("t5_addr", imem_addr, 16'h3000);
        chk("t5_cnt0", q_count, 0);
        tick();
        imem_r = 1;
        ld_de  = 1;
        for (int i = 0; i < 4; i++) begin
            instr = 16'h5000 + 16'(i);
            settle();
            if (de_v) chk("t5_nodrop", de_ir == 16'hDEAD, 0);
            tick();
        end

        // PC wrap and vector loads
        ld_de     = 0;
        imem_r    = 0;
        mem_pcmux = 1;
        target_pc = 16'hFFFE;
        cyc();
        mem_pcmux = 0;
        imem_r    = 1;
        instr     = 16'h1234;
        cyc();
        imem_r = 0;
        settle();
        chk("t6_pc", pc, 16'h0000);
        chk("t6_npc", de_npc, 16'h0000);
        chk("t6_ir", de_ir, 16'h1234);
        tick();
        mem_pcmux = 2;
        trap_pc   = 16'h0200;
        cyc();
        mem_pcmux = 0;
        settle();
        chk("t6_trap", pc, 16'h0200);
        tick();
        mem_pcmux = 3;
        cyc();
        mem_pcmux = 0;
        settle();
        chk("t6_zero", pc, 16'h0000);
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            imem_r    = ($urandom_range(0, 9) < 7);
            ld_de     = $urandom_range(0, 1) == 1;
            instr     = 16'($urandom);
            target_pc = 16'($urandom) & 16'hFFFE;
            trap_pc   = 16'($urandom) & 16'hFFFE;
            mem_pcmux = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            br_stall  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            reset     = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
